// File: rtl/tow_match_core.sv
// Tug-of-war match core: rope position display, round scoring, win blink
// and match termination for two debounced pushbuttons.
//
// state       | meaning
// ------------|-------------------------------------------------------------
// S_BLANK     | display dark for START_DLY cycles, pushes ignored
// S_PLAY      | rope live, one-hot position shown, pushes move the rope
// S_ROUND_WIN | winner side blinks for WIN_HOLD cycles, score already bumped
// S_MATCH     | match decided, winner side blinks until reset
module tow_match_core #(
  parameter int NUM_LEDS    = 7,
  parameter int WIN_ROUNDS  = 3,
  parameter int SCORE_W     = 2,
  parameter int START_DLY   = 4,
  parameter int WIN_HOLD    = 16,
  parameter int BLINK_CYC   = 2,
  parameter int FAVOR_LOSER = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pbl,
  input  logic                pbr,
  output logic [NUM_LEDS-1:0] leds_out,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic                match_over,
  output logic                winner
);

  localparam int C       = (NUM_LEDS - 1) / 2;
  localparam int POS_W   = $clog2(NUM_LEDS);
  localparam int DLY_MAX = (START_DLY > WIN_HOLD) ? START_DLY : WIN_HOLD;
  localparam int CNT_W   = $clog2(DLY_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_CYC + 1);

  localparam logic [POS_W-1:0]    POS_C   = POS_W'(C);
  localparam logic [POS_W-1:0]    POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [SCORE_W-1:0]  SC_WIN  = SCORE_W'(WIN_ROUNDS);
  localparam logic [NUM_LEDS-1:0] PAT_R   = NUM_LEDS'((1 << C) - 1);
  localparam logic [NUM_LEDS-1:0] PAT_L   = ~(PAT_R | (NUM_LEDS'(1) << C));

  typedef enum logic [1:0] {S_BLANK, S_PLAY, S_ROUND_WIN, S_MATCH} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   pos_l;
  logic [POS_W-1:0]   pos_r;
  logic               pbl_q;
  logic               pbr_q;
  logic               push_l;
  logic               push_r;
  logic               rnd_left;
  logic               blink_on;
  logic [BLK_W-1:0]   blink_cnt;
  logic [NUM_LEDS-1:0] win_pat;

  assign push_l  = pbl & ~pbl_q;
  assign push_r  = pbr & ~pbr_q;
  assign win_pat = rnd_left ? PAT_L : PAT_R;

  // Next rope position for a single push; the trailing side jumps two, capped at centre.
  always_comb begin
    pos_l = pos + POS_W'(1);
    pos_r = pos - POS_W'(1);
    if (FAVOR_LOSER != 0 && pos < POS_C) begin
      pos_l = (pos + POS_W'(2) > POS_C) ? POS_C : pos + POS_W'(2);
    end
    if (FAVOR_LOSER != 0 && pos > POS_C) begin
      pos_r = (pos - POS_W'(2) < POS_C) ? POS_C : pos - POS_W'(2);
    end
  end

  // Blink phase: parked "on" during play so every win display starts lit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (state == S_ROUND_WIN || state == S_MATCH) begin
      if (blink_cnt == BLK_W'(BLINK_CYC - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end else begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end
  end

  // Game FSM with edge detection, scoring and registered display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_BLANK;
      cnt        <= '0;
      pos        <= POS_C;
      score_l    <= '0;
      score_r    <= '0;
      match_over <= 1'b0;
      winner     <= 1'b0;
      leds_out   <= '0;
      pbl_q      <= 1'b0;
      pbr_q      <= 1'b0;
      rnd_left   <= 1'b0;
    end else begin
      pbl_q <= pbl;
      pbr_q <= pbr;
      case (state)
        S_BLANK: begin
          leds_out <= '0;
          if (cnt == CNT_W'(START_DLY - 1)) begin
            state <= S_PLAY;
            pos   <= POS_C;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PLAY: begin
          leds_out <= NUM_LEDS'(1) << pos;
          if (push_l && !push_r) begin
            if (pos == POS_MAX) begin
              state    <= S_ROUND_WIN;
              cnt      <= '0;
              rnd_left <= 1'b1;
              if (score_l != SC_WIN) score_l <= score_l + SCORE_W'(1);
            end else begin
              pos <= pos_l;
            end
          end else if (push_r && !push_l) begin
            if (pos == '0) begin
              state    <= S_ROUND_WIN;
              cnt      <= '0;
              rnd_left <= 1'b0;
              if (score_r != SC_WIN) score_r <= score_r + SCORE_W'(1);
            end else begin
              pos <= pos_r;
            end
          end
        end
        S_ROUND_WIN: begin
          leds_out <= blink_on ? win_pat : '0;
          if (cnt == CNT_W'(WIN_HOLD - 1)) begin
            cnt <= '0;
            if ((rnd_left ? score_l : score_r) == SC_WIN) begin
              state      <= S_MATCH;
              match_over <= 1'b1;
              winner     <= rnd_left;
            end else begin
              state <= S_BLANK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_MATCH: begin
          leds_out <= blink_on ? win_pat : '0;
        end
        default: begin
          state <= S_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
